// File: rtl/ddr2_bist_ctrl.sv
// DDR2 datapath BIST sequencer: writes a scrambler burst, reads it back,
// and checks each returned word against a regenerated pattern.
module ddr2_bist_ctrl #(
   parameter int unsigned NUM_WORDS = 16,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [4:0]        seed,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_we,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [4:0]        cmd_wdata,
   input  logic              rsp_valid,
   input  logic [4:0]        rsp_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count
);

   localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0]  LAST_RSP  = CNT_W'(NUM_WORDS - 1);
   localparam logic [4:0]        PAT_INIT  = 5'h1f;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state;
   logic [4:0]       gen_wr;
   logic [4:0]       gen_exp;
   logic [CNT_W-1:0] rsp_cnt;

   logic             cmd_hs_c;
   logic             rsp_chk_c;
   logic             rsp_last_c;
   logic [4:0]       seed_eff_c;
   logic [7:0]       err_next_c;

   // One step of the 5-bit scrambler shared by both generators
   function automatic logic [4:0] pat_step(input logic [4:0] d);
      logic [4:0] n;
      n[4] = d[4] ^ d[1];
      n[3] = d[3] ^ d[0];
      n[2] = d[2] ^ n[4];
      n[1] = d[1] ^ n[3];
      n[0] = d[0] ^ n[2];
      return n;
   endfunction

   // All-zero would lock the scrambler, so it is swapped for all-ones
   assign seed_eff_c = (seed == 5'd0) ? PAT_INIT : seed;
   assign cmd_hs_c   = cmd_valid & cmd_ready;
   assign rsp_chk_c  = rsp_valid & ((state == S_READ) | (state == S_DRAIN));
   assign rsp_last_c = rsp_chk_c & (rsp_cnt == LAST_RSP);
   assign err_next_c = (rsp_chk_c && (rsp_rdata != gen_exp) && (err_count != 8'hff))
                       ? err_count + 8'd1 : err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cmd_valid <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 8'd0;
         gen_wr    <= PAT_INIT;
         gen_exp   <= PAT_INIT;
         rsp_cnt   <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_we    <= 1'b0;
            busy      <= 1'b0;
            pass      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state     <= S_WRITE;
                     gen_wr    <= seed_eff_c;
                     gen_exp   <= seed_eff_c;
                     cmd_wdata <= seed_eff_c;
                     cmd_addr  <= '0;
                     cmd_valid <= 1'b1;
                     cmd_we    <= 1'b1;
                     busy      <= 1'b1;
                     err_count <= 8'd0;
                     pass      <= 1'b0;
                     rsp_cnt   <= '0;
                  end
               end
               S_WRITE: begin
                  if (cmd_hs_c) begin
                     gen_wr    <= pat_step(gen_wr);
                     cmd_wdata <= pat_step(gen_wr);
                     if (cmd_addr == LAST_ADDR) begin
                        // Reads follow back-to-back with no bubble
                        cmd_addr <= '0;
                        cmd_we   <= 1'b0;
                        state    <= S_READ;
                     end else begin
                        cmd_addr <= cmd_addr + ADDR_W'(1);
                     end
                  end
               end
               S_READ: begin
                  if (cmd_hs_c) begin
                     cmd_addr <= cmd_addr + ADDR_W'(1);
                     if (cmd_addr == LAST_ADDR) begin
                        cmd_valid <= 1'b0;
                        state     <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: ;
               S_DONE: state <= S_IDLE;
               default: begin
                  state     <= S_IDLE;
                  cmd_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase

            // Response check overrides READ transitions so a zero-latency final word completes
            if (rsp_chk_c) begin
               gen_exp   <= pat_step(gen_exp);
               rsp_cnt   <= rsp_cnt + CNT_W'(1);
               err_count <= err_next_c;
               if (rsp_last_c) begin
                  state     <= S_DONE;
                  cmd_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= (err_next_c == 8'd0);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr2_bist_ctrl.sv
// Self-checking bench for ddr2_bist_ctrl: a memory/responder model with
// configurable ready pattern, latency and corruption, plus a pattern reference.
module tb_ddr2_bist_ctrl;

   localparam int unsigned NW = 4;
   localparam int unsigned AW = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [4:0]    seed;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [4:0]    cmd_wdata;
   logic          rsp_valid;
   logic [4:0]    rsp_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [7:0]    err_count;

   ddr2_bist_ctrl #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .seed      (seed),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference scrambler written in closed form from the seed bits
   function automatic logic [4:0] ref_step(input logic [4:0] d);
      logic [4:0] n;
      n[4] = d[4] ^ d[1];
      n[3] = d[3] ^ d[0];
      n[2] = d[2] ^ d[4] ^ d[1];
      n[1] = d[1] ^ d[3] ^ d[0];
      n[0] = d[0] ^ d[2] ^ d[4] ^ d[1];
      return n;
   endfunction

   // Responder configuration (written by the stimulus block only)
   int ready_mode  = 0;
   int lat         = 2;
   int corrupt_idx = -1;

   // Responder / monitor state
   int          cyc          = 0;
   logic [4:0]  mem [256];
   logic [4:0]  pend_data [$];
   int          pend_due  [$];
   logic [AW-1:0] wr_addr [$];
   logic [4:0]  wr_data [$];
   logic [AW-1:0] rd_addr [$];
   int          delivered    = 0;
   int          done_cnt     = 0;
   int          done_cyc     = 0;
   int          last_rsp_cyc = -100;
   int          stall_viol   = 0;
   int          stall_events = 0;
   logic        prev_stall   = 1'b0;
   logic [AW-1:0] sv_addr;
   logic [4:0]  sv_wdata;
   logic        sv_we;
   logic [4:0]  rtmp;

   always @(negedge clk) begin
      cyc++;
      case (ready_mode)
         0:       cmd_ready = 1'b1;
         1:       cmd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
      if (start && !abort && !busy && !done) begin
         wr_addr.delete(); wr_data.delete(); rd_addr.delete();
         delivered = 0; done_cnt = 0; done_cyc = 0; last_rsp_cyc = -100;
      end
      if (rst_n && !abort && cmd_valid && cmd_ready) begin
         if (cmd_we) begin
            mem[cmd_addr] = cmd_wdata;
            wr_addr.push_back(cmd_addr);
            wr_data.push_back(cmd_wdata);
         end else begin
            rd_addr.push_back(cmd_addr);
            pend_data.push_back(mem[cmd_addr]);
            pend_due.push_back(cyc + lat);
         end
      end
      if (prev_stall) begin
         stall_events++;
         if (!cmd_valid || cmd_addr !== sv_addr || cmd_wdata !== sv_wdata || cmd_we !== sv_we)
            stall_viol++;
      end
      prev_stall = rst_n && cmd_valid && !cmd_ready && !abort;
      sv_addr = cmd_addr; sv_wdata = cmd_wdata; sv_we = cmd_we;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         rtmp = pend_data.pop_front();
         void'(pend_due.pop_front());
         if (delivered == corrupt_idx) rtmp = rtmp ^ 5'h01;
         rsp_valid = 1'b1;
         rsp_rdata = rtmp;
         delivered++;
         if (delivered == NW) last_rsp_cyc = cyc;
      end else begin
         rsp_valid = 1'b0;
         rsp_rdata = 5'($urandom);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic pulse_start(input logic [4:0] sd);
      @(posedge clk); #1;
      seed  = sd;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [4:0] sd, input int exp_err);
      logic [4:0] p;
      int         nw;
      int         nr;
      p  = (sd == 5'd0) ? 5'h1f : sd;
      nw = (wr_data.size() < NW) ? wr_data.size() : NW;
      nr = (rd_addr.size() < NW) ? rd_addr.size() : NW;
      chk({tag, ".n_writes"}, wr_data.size(), NW);
      for (int i = 0; i < nw; i++) begin
         chk($sformatf("%s.wr_addr%0d", tag, i), wr_addr[i], i);
         chk($sformatf("%s.wr_data%0d", tag, i), wr_data[i], p);
         p = ref_step(p);
      end
      chk({tag, ".n_reads"}, rd_addr.size(), NW);
      for (int i = 0; i < nr; i++)
         chk($sformatf("%s.rd_addr%0d", tag, i), rd_addr[i], i);
      chk({tag, ".err_count"}, err_count, exp_err);
      chk({tag, ".pass"}, pass, (exp_err == 0) ? 1 : 0);
      chk({tag, ".done_pulses"}, done_cnt, 1);
      chk({tag, ".done_latency"}, done_cyc - last_rsp_cyc, 1);
      chk({tag, ".busy_idle"}, busy, 1'b0);
   endtask

   task automatic run_test(input string tag, input logic [4:0] sd, input int rm, input int lt,
                           input int ci, input bit mid_start);
      int exp_err;
      ready_mode  = rm;
      lat         = lt;
      corrupt_idx = ci;
      exp_err     = (ci >= 0 && ci < NW) ? 1 : 0;
      pulse_start(sd);
      if (mid_start) begin
         repeat (3) @(posedge clk);
         #1; seed = ~sd; start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
      end
      wait_done();
      check_result(tag, sd, exp_err);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.cmd_valid", cmd_valid, 1'b0);
      chk("rst.cmd_we",    cmd_we,    1'b0);
      chk("rst.cmd_addr",  cmd_addr,  0);
      chk("rst.cmd_wdata", cmd_wdata, 0);
      chk("rst.busy",      busy,      1'b0);
      chk("rst.done",      done,      1'b0);
      chk("rst.pass",      pass,      1'b0);
      chk("rst.err_count", err_count, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_test("basic",   5'h1f, 0, 2, -1, 1'b0);
      run_test("corrupt", 5'h1f, 0, 2,  2, 1'b0);
      run_test("seed0",   5'h00, 0, 2, -1, 1'b0);
      run_test("stall",   5'h1f, 1, 2, -1, 1'b0);
      chk("stall.events_seen", (stall_events > 0) ? 1 : 0, 1);
      chk("stall.stable", stall_viol, 0);

      // Abort once two responses have been sampled; the corrupted late word must be ignored
      ready_mode = 1; lat = 1; corrupt_idx = 3;
      pulse_start(5'h0b);
      for (int i = 0; i < 200 && delivered < 2; i++) begin
         @(posedge clk); #1;
      end
      chk("abort.reached_two_rsp", (delivered >= 2) ? 1 : 0, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort.busy",      busy,      1'b0);
      chk("abort.cmd_valid", cmd_valid, 1'b0);
      chk("abort.done",      done,      1'b0);
      chk("abort.pass",      pass,      1'b0);
      chk("abort.err_hold",  err_count, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("abort.late_err",  err_count, 0);
      chk("abort.no_done",   done_cnt,  0);
      run_test("rerun",   5'h1f, 0, 2, -1, 1'b0);

      run_test("zero_lat", 5'h1f, 0, 0, -1, 1'b1);

      for (int k = 0; k < 6; k++) begin
         logic [4:0] sd;
         int         ci;
         sd = 5'($urandom);
         ci = $urandom_range(0, 7);
         if (ci >= NW) ci = -1;
         run_test($sformatf("rand%0d", k), sd, $urandom_range(0, 2), $urandom_range(0, 3), ci, 1'b0);
      end
      chk("final.stable", stall_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr2_bist_ctrl.md
Name: ddr2_bist_ctrl

Overview:
Built-in self-test sequencer for the DDR2 datapath. On start it writes a scrambler-pattern burst to consecutive addresses, then reads the burst back and checks each returned word against a regenerated pattern. It reports the mismatch count and a pass flag. It sits between the test/debug register block and the memory command port, and owns both the write-side and the check-side pattern generators.

Parameters:
NUM_WORDS, 16, words per test burst; legal range 2..256.
ADDR_W, 8, command address width; must satisfy 2^ADDR_W >= NUM_WORDS.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a test; honoured only in IDLE
abort  in  1  return to IDLE immediately; no done pulse
seed  in  5  pattern seed, latched on an accepted start
cmd_valid  out  1  memory command valid
cmd_ready  in  1  memory command accept
cmd_we  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_W  command word address
cmd_wdata  out  5  write data
rsp_valid  in  1  read response valid; responses arrive in order, with arbitrary latency of 0 or more cycles
rsp_rdata  in  5  read response data
busy  out  1  high in WRITE, READ and DRAIN
done  out  1  one-cycle pulse when the test completes
pass  out  1  high when err_count == 0 at completion; held until the next accepted start
err_count  out  8  mismatch count, saturating at 255

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - state = IDLE
  - cmd_valid, cmd_we, busy, done, pass = 0
  - cmd_addr, cmd_wdata, err_count = 0
  - both generators = 5'h1f
- Pattern step function, where d is the current value and n the next:
  - n4 = d4^d1
  - n3 = d3^d0
  - n2 = d2^n4
  - n1 = d1^n3
  - n0 = d0^n2
- Zero is a lock-up state, so seed = 0 is replaced by 5'h1f at latch time.
- Two independent generators, each 5 bits:
  - gen_wr: supplies cmd_wdata.
  - gen_exp: supplies the expected read data.
- IDLE:
  - cmd_valid = 0.
  - On start (with abort low): gen_wr = gen_exp = effective seed; addr = 0; err_count = 0; pass = 0; rsp counter = 0; go to WRITE.
- WRITE:
  - cmd_valid = 1, cmd_we = 1, cmd_addr = addr, cmd_wdata = gen_wr.
  - Outputs stay stable while cmd_ready is low.
  - On handshake (cmd_valid & cmd_ready): gen_wr steps and addr increments.
  - Handshake at addr == NUM_WORDS-1: addr = 0, go to READ. No idle cycle is inserted between the last write and the first read command.
- READ:
  - cmd_valid = 1, cmd_we = 0, cmd_addr = addr.
  - On handshake, addr increments.
  - Handshake at addr == NUM_WORDS-1: go to DRAIN.
- Response checking is active in READ and DRAIN. Each cycle with rsp_valid = 1:
  - Compare rsp_rdata with gen_exp.
  - On mismatch, err_count increments, saturating at 255.
  - gen_exp steps and the response counter increments.
- A response may arrive in the same cycle as its own command handshake (zero latency).
- Completion: when the response counter reaches NUM_WORDS, from READ or DRAIN, go to DONE.
  - The final comparison is included in err_count and pass.
- rsp_valid in IDLE, WRITE or DONE is ignored: no compare and no counter change.
- DONE (one cycle):
  - done = 1, busy = 0, cmd_valid = 0.
  - pass = (err_count == 0), using the final count.
  - Next state is IDLE.
- Outputs are registered.
  - busy rises the cycle after an accepted start.
  - done asserts the cycle after the final response is sampled.
- abort:
  - Has priority over everything else in any state.
  - Next cycle: state = IDLE, cmd_valid = 0, busy = 0, no done pulse, pass = 0.
  - err_count keeps its value.
  - Any in-flight responses that arrive later are ignored.
- start while busy is ignored. start and abort in the same cycle: abort wins.

Test Plan:
- NUM_WORDS=4, seed=5'h1f, cmd_ready=1, responses echo the written data with 2-cycle latency -> write data 1f,06,12,02 at addresses 0..3; reads at addresses 0..3; done pulse; pass=1; err_count=0.
- Same setup, but response word 2 is returned as 5'h13 -> err_count=1, pass=0, done still pulses once.
- seed=0 -> cmd_wdata sequence 1f,06,12,02 (seed substituted).
- cmd_ready toggles 1,0,0,1 repeatedly -> cmd_addr, cmd_wdata and cmd_we stay stable while stalled; exactly 4 writes then 4 reads are issued; pass=1.
- abort asserted during READ after 2 responses -> next cycle busy=0 and cmd_valid=0; no done; pass=0; late responses leave err_count unchanged; a new start reruns the test to pass=1.
- Zero-latency responses (rsp_valid in the same cycle as the read handshake), plus start pulsed mid-test -> start ignored; done asserts the cycle after the 4th response; pass=1.
